// File: rtl/gate_tt_sequencer_if.sv
// gate_tt_sequencer_if: sweep control, gate stimulus and result bundle for gate_tt_sequencer.
interface gate_tt_sequencer_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            dut_out;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;
    modport master (
        output start, dut_out,
        input  vec, busy, done, pass, err_cnt, first_err_vec, first_err_valid
    );
    modport slave (
        input  start, dut_out,
        output vec, busy, done, pass, err_cnt, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: sweeps all input vectors of a small gate and checks its output against TRUTH.
// Define TT_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module gate_tt_sequencer #(
    parameter int                   N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] TRUTH    = 8'hFE,
    parameter int                   HOLD_CYC = 10
) (
    input logic                clk,
    input logic                rst,
    gate_tt_sequencer_if.slave bus
);
    localparam int H  = HOLD_CYC < 1 ? 1 : HOLD_CYC;
    localparam int HW = $clog2(H + 1);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    state_t          state, state_n;
    logic [N_IN-1:0] vec, vec_n, fev, fev_n;
    logic [HW-1:0]   hcnt, hcnt_n;
    logic [N_IN:0]   err_cnt, err_n;
    logic            fevld, fevld_n, pass, pass_n;
    logic            mis, fin;
    assign mis = bus.dut_out != TRUTH[vec];
`ifdef TT_STOP_ON_ERR_EN
    assign fin = mis || (&vec);
`else
    assign fin = &vec;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            vec     <= '0;
            hcnt    <= '0;
            err_cnt <= '0;
            fev     <= '0;
            fevld   <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state   <= state_n;
            vec     <= vec_n;
            hcnt    <= hcnt_n;
            err_cnt <= err_n;
            fev     <= fev_n;
            fevld   <= fevld_n;
            pass    <= pass_n;
        end
    end
    always_comb begin
        state_n = state;
        vec_n   = vec;
        hcnt_n  = hcnt;
        err_n   = err_cnt;
        fev_n   = fev;
        fevld_n = fevld;
        pass_n  = pass;
        unique case (state)
            IDLE: begin
                vec_n = '0;
                if (bus.start) begin
                    state_n = APPLY;
                    hcnt_n  = '0;
                    err_n   = '0;
                    fev_n   = '0;
                    fevld_n = 1'b0;
                    pass_n  = 1'b0;
                end
            end
            APPLY: begin
                hcnt_n  = hcnt + 1'b1;
                state_n = hcnt == HW'(H - 1) ? SAMPLE : APPLY;
            end
            SAMPLE: begin
                if (mis) begin
                    err_n   = &err_cnt ? err_cnt : err_cnt + 1'b1;
                    fev_n   = fevld ? fev : vec;
                    fevld_n = 1'b1;
                end
                // vec stays put on the final (or stopping) vector so DONE shows where the sweep ended
                state_n = fin ? DONE : APPLY;
                vec_n   = fin ? vec : vec + 1'b1;
                hcnt_n  = '0;
            end
            DONE: begin
                pass_n  = err_cnt == '0;
                vec_n   = '0;
                state_n = IDLE;
            end
        endcase
    end
    assign bus.vec             = vec;
    assign bus.busy            = state != IDLE;
    assign bus.done            = state == DONE;
    assign bus.pass            = pass;
    assign bus.err_cnt         = err_cnt;
    assign bus.first_err_vec   = fev;
    assign bus.first_err_valid = fevld;
endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Synthesizable truth-table sweep controller for small combinational gates such as the 3-input AND/OR/XOR family.
- Drives every input vector 0..2^N_IN-1 onto the gate, holds each vector for a settle period, samples the gate output, and compares it against an expected truth-table parameter.
- Reports the mismatch count, the first failing vector and pass/fail status.
- Used as the on-chip self-check companion of each gate in the logic-gate library.

Parameters:
- N_IN, 3, number of gate inputs (1..4).
- TRUTH, 8'hFE, expected output; bit i = expected output for input vector i (2^N_IN bits wide). Default is 3-input OR.
- HOLD_CYC, 10, cycles each vector is held before sampling (values below 1 are treated as 1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- dut_out  input  1  output of the gate under check.
- vec  output  N_IN  gate input vector; vec[N_IN-1] drives the first gate input (a), vec[0] drives the last (c).
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the last sweep had err_cnt==0; valid after done.
- err_cnt  output  N_IN+1  mismatch count of the current/last sweep.
- first_err_vec  output  N_IN  vector of the first mismatch.
- first_err_valid  output  1  at least one mismatch has been recorded.

Behaviour:
- Reset (rst=1 at a clock edge), including mid-sweep: on the next cycle state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0, hold counter=0.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - vec=0; result outputs hold their last values.
  - start=1 → APPLY. On the same edge: clear err_cnt, first_err_vec, first_err_valid and pass; set vec=0 and hold counter=0.
- APPLY:
  - vec held stable; hold counter increments each cycle.
  - After HOLD_CYC cycles in APPLY → SAMPLE.
- SAMPLE (1 cycle):
  - mismatch = dut_out != TRUTH[vec].
  - On mismatch: err_cnt+1, saturating at 2^(N_IN+1)-1. If first_err_valid=0, capture first_err_vec=vec and set first_err_valid=1.
  - If vec==2^N_IN-1 → DONE. Otherwise vec+1 and clear the hold counter → APPLY.
  - vec never wraps inside a sweep.
- DONE (1 cycle):
  - done=1, pass=(err_cnt==0), then → IDLE.
  - err_cnt, pass and first_err_* hold until the next accepted start or reset.
- Latency: with start sampled at edge E0, done is high in cycle 2^N_IN*(HOLD_CYC+1)+1 after E0. For defaults this is 89.
- Per-vector period: HOLD_CYC+1 cycles.
- busy is high for exactly 2^N_IN*(HOLD_CYC+1)+1 cycles.
- start while busy is ignored: no restart, no queuing.
- start asserted in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- rst and start asserted together: rst wins.
- dut_out is sampled only in SAMPLE. Glitches during APPLY are irrelevant.

Optional Feature:
- Macro: TT_STOP_ON_ERR_EN.
- Defined: the first mismatch in SAMPLE transitions directly to DONE (vec not incremented). err_cnt is then 0 or 1, and done arrives early at cycle (k+1)*(HOLD_CYC+1)+1 for a first failing vector k.
- Undefined: the full sweep always runs, and every mismatch is counted.

Test Plan:
1. Ideal OR model (dut_out=|vec), defaults, start pulse at E0 → vec steps 0..7, each held 11 cycles; done at cycle 89; pass=1; err_cnt=0; first_err_valid=0.
2. dut_out tied to 0, TRUTH=8'hFE → err_cnt=7, first_err_vec=3'd1, first_err_valid=1, pass=0, done at cycle 89.
3. AND model (dut_out=&vec), TRUTH=8'hFE → mismatches on vectors 1..6; err_cnt=6; first_err_vec=1; pass=0.
4. rst=1 at cycle 30 of a sweep → next cycle busy=0, vec=0, err_cnt=0, no done pulse. A new start afterwards gives a full 89-cycle sweep.
5. start re-pulsed at cycles 40 and 89 of a sweep → no effect; exactly one done pulse. start at cycle 90 begins a new sweep and clears the results.
6. TT_STOP_ON_ERR_EN defined, dut_out tied to 0 → done at cycle 23, err_cnt=1, first_err_vec=1, vec remains 1 during DONE.
